// File: rtl/st2ld_fwd_cache_pkg.sv
// Shared sizing constants and entry type for the store-to-load forwarding cache.
package st2ld_fwd_cache_pkg;

  localparam int unsigned STBUFF_DEPTH = 16;
  localparam int unsigned XLEN         = 64;
  localparam logic [XLEN-1:0] MMAP_MASK = 64'hffff_ffff_e000_0000;

  localparam int unsigned SB_IDX_W    = $clog2(STBUFF_DEPTH);
  localparam int unsigned ST2LD_IDX_W = $clog2(STBUFF_DEPTH);
  localparam int unsigned ST2LD_TAG_W = XLEN - ST2LD_IDX_W - 3;

  typedef struct packed {
    logic                   valid;
    logic [ST2LD_TAG_W-1:0] tag;
    logic [SB_IDX_W-1:0]    sb_idx;
  } st2ld_entry_t;

endpackage

// File: rtl/st2ld_fwd_cache.sv
// Direct-mapped cache mapping doubleword addresses to the latest store buffer entry.
// Optional hit/miss counters are built when ST2LD_FWD_PERF_CNT_EN is defined.
module st2ld_fwd_cache
  import st2ld_fwd_cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                upd_valid_i,
  input  logic [XLEN-1:0]     upd_addr_i,
  input  logic [SB_IDX_W-1:0] upd_sb_idx_i,
  input  logic                inv_valid_i,
  input  logic [SB_IDX_W-1:0] inv_sb_idx_i,
  input  logic                lkp_valid_i,
  input  logic [XLEN-1:0]     lkp_addr_i,
`ifdef ST2LD_FWD_PERF_CNT_EN
  output logic [63:0]         hit_cnt_o,
  output logic [63:0]         miss_cnt_o,
`endif
  output logic                lkp_hit_o,
  output logic [SB_IDX_W-1:0] lkp_sb_idx_o
);

  localparam int unsigned DEPTH = STBUFF_DEPTH;

  logic                   valid  [DEPTH];
  logic [ST2LD_TAG_W-1:0] tags   [DEPTH];
  logic [SB_IDX_W-1:0]    sb_idxs[DEPTH];

  logic [ST2LD_IDX_W-1:0] upd_idx;
  logic [ST2LD_TAG_W-1:0] upd_tag;
  logic                   upd_en;
  logic [ST2LD_IDX_W-1:0] lkp_idx;
  logic [ST2LD_TAG_W-1:0] lkp_tag;
  logic                   lkp_mmap;
  st2ld_entry_t           sel;
  logic                   hit;

  always_comb begin
    upd_idx = upd_addr_i[ST2LD_IDX_W+2:3];
    upd_tag = upd_addr_i[XLEN-1:ST2LD_IDX_W+3];
    upd_en  = upd_valid_i & ~(|(upd_addr_i & MMAP_MASK));
  end

  // Only valid bits carry reset; update beats invalidate on the same entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (upd_en && upd_idx == ST2LD_IDX_W'(i))
          valid[i] <= 1'b1;
        else if (inv_valid_i && sb_idxs[i] == inv_sb_idx_i)
          valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_en) begin
      tags[upd_idx]    <= upd_tag;
      sb_idxs[upd_idx] <= upd_sb_idx_i;
    end
  end

  always_comb begin
    lkp_idx  = lkp_addr_i[ST2LD_IDX_W+2:3];
    lkp_tag  = lkp_addr_i[XLEN-1:ST2LD_IDX_W+3];
    lkp_mmap = |(lkp_addr_i & MMAP_MASK);
    sel      = '{valid: valid[lkp_idx], tag: tags[lkp_idx], sb_idx: sb_idxs[lkp_idx]};
    hit      = lkp_valid_i & sel.valid & (sel.tag == lkp_tag) & ~lkp_mmap;
  end

  assign lkp_hit_o    = hit;
  assign lkp_sb_idx_o = hit ? sel.sb_idx : '0;

`ifdef ST2LD_FWD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lkp_valid_i) begin
      if (hit) hit_cnt_o  <= hit_cnt_o + 64'd1;
      else     miss_cnt_o <= miss_cnt_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_st2ld_fwd_cache.sv
// Directed self-checking bench for st2ld_fwd_cache (counters checked when ST2LD_FWD_PERF_CNT_EN is defined).
module tb_st2ld_fwd_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        upd_valid;
  logic [63:0] upd_addr;
  logic [3:0]  upd_sb_idx;
  logic        inv_valid;
  logic [3:0]  inv_sb_idx;
  logic        lkp_valid;
  logic [63:0] lkp_addr;
  logic        lkp_hit;
  logic [3:0]  lkp_sb_idx;
`ifdef ST2LD_FWD_PERF_CNT_EN
  logic [63:0] hit_cnt;
  logic [63:0] miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  st2ld_fwd_cache dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .upd_valid_i  (upd_valid),
    .upd_addr_i   (upd_addr),
    .upd_sb_idx_i (upd_sb_idx),
    .inv_valid_i  (inv_valid),
    .inv_sb_idx_i (inv_sb_idx),
    .lkp_valid_i  (lkp_valid),
    .lkp_addr_i   (lkp_addr),
`ifdef ST2LD_FWD_PERF_CNT_EN
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt),
`endif
    .lkp_hit_o    (lkp_hit),
    .lkp_sb_idx_o (lkp_sb_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; upd_valid = 0; inv_valid = 0; lkp_valid = 0;
    upd_addr = '0; upd_sb_idx = '0; inv_sb_idx = '0; lkp_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    lkp_valid = 1; lkp_addr = 64'h1000;
    #2;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL reset_during: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_valid = 0;
    tick(); tick();
    @(negedge clk); rst = 0;
    lkp_valid = 1; lkp_addr = 64'h1000;
    #1;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL reset_lookup: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_valid = 0;
  endtask

  task automatic test_basic_hit();
    idle();
    upd_valid = 1; upd_addr = 64'h1008; upd_sb_idx = 4'd5;
    lkp_valid = 1; lkp_addr = 64'h1008;
    #1;
    tests++;
    if (lkp_hit !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle_invisible: hit=%b required 0", lkp_hit);
    end
    tick();
    upd_valid = 0;
    lkp_addr = 64'h100C;
    #1;
    tests++;
    if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'd5) begin
      fails++;
      $display("FAIL basic_hit: hit=%b idx=%0d required hit=1 idx=5", lkp_hit, lkp_sb_idx);
    end
    lkp_addr = 64'h2008;
    #1;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL alias_miss: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_valid = 0; lkp_addr = 64'h1008;
    #1;
    tests++;
    if (lkp_hit !== 1'b0) begin
      fails++;
      $display("FAIL lkp_valid_low: hit=%b required 0", lkp_hit);
    end
  endtask

  task automatic test_overwrite_inv();
    idle();
    upd_valid = 1; upd_addr = 64'h1008; upd_sb_idx = 4'd5;
    tick();
    upd_sb_idx = 4'd9;
    tick();
    upd_valid = 0;
    lkp_valid = 1; lkp_addr = 64'h1008;
    #1;
    tests++;
    if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'd9) begin
      fails++;
      $display("FAIL overwrite: hit=%b idx=%0d required hit=1 idx=9", lkp_hit, lkp_sb_idx);
    end
    inv_valid = 1; inv_sb_idx = 4'd5;
    tick();
    inv_valid = 0;
    #1;
    tests++;
    if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'd9) begin
      fails++;
      $display("FAIL inv_other: hit=%b idx=%0d required hit=1 idx=9", lkp_hit, lkp_sb_idx);
    end
    inv_valid = 1; inv_sb_idx = 4'd9;
    tick();
    inv_valid = 0;
    #1;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL inv_match: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_valid = 0;
  endtask

  task automatic test_mmap();
    idle();
    upd_valid = 1; upd_addr = 64'h0; upd_sb_idx = 4'd2;
    tick();
    upd_addr = 64'h2000_0000; upd_sb_idx = 4'd3;
    tick();
    upd_valid = 0;
    lkp_valid = 1; lkp_addr = 64'h2000_0000;
    #1;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL mmap_miss: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_addr = 64'h0;
    #1;
    tests++;
    if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'd2) begin
      fails++;
      $display("FAIL mmap_no_modify: hit=%b idx=%0d required hit=1 idx=2", lkp_hit, lkp_sb_idx);
    end
    lkp_valid = 0;
  endtask

  task automatic test_same_cycle();
    idle();
    upd_valid = 1; upd_addr = 64'h40; upd_sb_idx = 4'd7;
    inv_valid = 1; inv_sb_idx = 4'd7;
    tick();
    upd_valid = 0; inv_valid = 0;
    lkp_valid = 1; lkp_addr = 64'h40;
    #1;
    tests++;
    if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'd7) begin
      fails++;
      $display("FAIL upd_beats_inv: hit=%b idx=%0d required hit=1 idx=7", lkp_hit, lkp_sb_idx);
    end
    upd_valid = 1; upd_addr = 64'h40; upd_sb_idx = 4'd4; flush = 1;
    tick();
    upd_valid = 0; flush = 0;
    #1;
    tests++;
    if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
      fails++;
      $display("FAIL flush_beats_upd: hit=%b idx=%0d required hit=0 idx=0", lkp_hit, lkp_sb_idx);
    end
    lkp_addr = 64'h0;
    #1;
    tests++;
    if (lkp_hit !== 1'b0) begin
      fails++;
      $display("FAIL flush_all: hit=%b required 0", lkp_hit);
    end
    lkp_valid = 0;
  endtask

  task automatic test_fill_async_reset();
    idle();
    for (int i = 0; i < 16; i++) begin
      upd_valid = 1; upd_addr = 64'(i) << 3; upd_sb_idx = 4'(i);
      tick();
    end
    upd_valid = 0;
    lkp_valid = 1;
    for (int i = 3; i < 16; i += 12) begin
      lkp_addr = 64'(i) << 3;
      #1;
      tests++;
      if (lkp_hit !== 1'b1 || lkp_sb_idx !== 4'(i)) begin
        fails++;
        $display("FAIL fill_hit[%0d]: hit=%b idx=%0d required hit=1 idx=%0d", i, lkp_hit, lkp_sb_idx, i);
      end
    end
    @(negedge clk);
    #2;
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      lkp_addr = 64'(i) << 3;
      #1;
      tests++;
      if (lkp_hit !== 1'b0 || lkp_sb_idx !== 4'd0) begin
        fails++;
        $display("FAIL async_reset[%0d]: hit=%b idx=%0d required hit=0 idx=0", i, lkp_hit, lkp_sb_idx);
      end
    end
`ifdef ST2LD_FWD_PERF_CNT_EN
    tests++;
    if (hit_cnt !== 64'd0 || miss_cnt !== 64'd0) begin
      fails++;
      $display("FAIL perf_reset: hit_cnt=%0d miss_cnt=%0d required 0 0", hit_cnt, miss_cnt);
    end
`endif
    lkp_valid = 0;
    @(negedge clk); rst = 0;
`ifdef ST2LD_FWD_PERF_CNT_EN
    upd_valid = 1; upd_addr = 64'h18; upd_sb_idx = 4'd6;
    tick();
    upd_valid = 0;
    lkp_valid = 1; lkp_addr = 64'h18;
    tick();
    lkp_addr = 64'h2000_0018;
    tick();
    lkp_addr = 64'h58;
    tick();
    lkp_valid = 0;
    tests++;
    if (hit_cnt !== 64'd1 || miss_cnt !== 64'd2) begin
      fails++;
      $display("FAIL perf_count: hit_cnt=%0d miss_cnt=%0d required 1 2", hit_cnt, miss_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_overwrite_inv();
    test_mmap();
    test_same_cycle();
    test_fill_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
